// File: rtl/lane_copier_pkg.sv
// lane_copier_pkg
//   Shared definitions for the lane copier pipeline: the 2-bit operation
//   encoding, default geometry constants and a helper that widens a
//   per-lane select mask into a per-bit mask.
package lane_copier_pkg;

  typedef enum logic [1:0] {
    MODE_COPY   = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_NEGATE = 2'd2,
    MODE_BCAST  = 2'd3
  } mode_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_LANE_W = 8;

  // Upper bound on channel width handled by expand_mask; callers cast the
  // result down to their own DATA_W.
  localparam int MAX_IDX_W  = 8;
  localparam int MAX_DATA_W = 1 << MAX_IDX_W;
  localparam int MAX_LANES  = MAX_DATA_W;

  // Lane i of the result is all ones iff mask[i] is set.
  function automatic logic [MAX_DATA_W-1:0] expand_mask(
    input logic [MAX_LANES-1:0] mask,
    input int                   lane_w,
    input int                   nlanes
  );
    logic [MAX_DATA_W-1:0] res;
    int                    bit_idx;
    res = '0;
    for (int i = 0; i < nlanes; i++) begin
      for (int b = 0; b < lane_w; b++) begin
        bit_idx = i * lane_w + b;
        res[bit_idx[MAX_IDX_W-1:0]] = mask[i[MAX_IDX_W-1:0]];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lane_copier_if.sv
// lane_copier_if
//   Bundles the input and output valid/ready streams of the lane copier.
//   master : upstream/downstream environment side (drives in_*, out_ready)
//   slave  : the copier itself (drives in_ready, out_valid, out_data)
//   in_data / out_data pack channel c at bits [c*DATA_W +: DATA_W].
interface lane_copier_if
  import lane_copier_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANE_W = DEF_LANE_W,
  parameter int NCH    = 2
);
  localparam int NLANES = DATA_W / LANE_W;

  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            in_mode;
  logic [NLANES-1:0]     in_mask;
  logic [NCH*DATA_W-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [NCH*DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_mode, in_mask, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_mask, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/lane_copier_op.sv
// lane_copier_op
//   Combinational second-stage operation for one channel.
//   i_x    : channel data already ANDed with the lane mask
//   i_m    : lane mask expanded to one bit per data bit
//   i_l    : broadcast source lane (lowest selected lane, 0 if none)
//   i_mode : operation select
//   o_y    : result, unselected lanes forced to zero
module lane_copier_op
  import lane_copier_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_m,
  input  logic [LANE_W-1:0] i_l,
  input  mode_e             i_mode,
  output logic [DATA_W-1:0] o_y
);
  localparam int NLANES = DATA_W / LANE_W;

  always_comb begin
    o_y = '0;
    case (i_mode)
      MODE_COPY:   o_y = i_x;
      MODE_INVERT: o_y = ~i_x & i_m;
      // Full-width subtraction: borrows ripple through unselected lanes
      // and are only discarded by the final mask.
      MODE_NEGATE: o_y = ({DATA_W{1'b0}} - i_x) & i_m;
      MODE_BCAST:  o_y = {NLANES{i_l}} & i_m;
    endcase
  end

endmodule

// File: rtl/lane_copier_pipe.sv
// lane_copier_pipe
//   Two-stage valid/ready pipeline applying a masked lane operation to NCH
//   independent channels. S1 captures masked data, mask, mode and the
//   broadcast lane; S2 holds the computed result and drives the outputs.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears both stages
//   bus : lane_copier_if slave modport (in_* stream in, out_* stream out)
module lane_copier_pipe
  import lane_copier_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANE_W = DEF_LANE_W,
  parameter int NCH    = 2
) (
  input  logic          clk,
  input  logic          rst,
  lane_copier_if.slave  bus
);
  localparam int NLANES = DATA_W / LANE_W;
  localparam int BUS_W  = NCH * DATA_W;

  // Stage registers
  logic              r_s1_valid;
  logic [BUS_W-1:0]  r_s1_x;
  logic [DATA_W-1:0] r_s1_m;
  mode_e             r_s1_mode;
  logic [NCH*LANE_W-1:0] r_s1_l;
  logic              r_s2_valid;
  logic [BUS_W-1:0]  r_s2_data;

  // Combinational helpers
  logic              w_s1_adv;
  logic              w_s2_adv;
  logic [DATA_W-1:0] w_m;
  logic [NLANES-1:0] w_first;
  logic              w_seen;
  logic [BUS_W-1:0]  w_x;
  logic [NCH*LANE_W-1:0] w_l;
  logic [BUS_W-1:0]  w_y;

  // A stage moves when it is empty or its successor is moving, so a full
  // pipeline with out_ready high streams one beat per cycle.
  assign w_s2_adv     = !r_s2_valid || bus.out_ready;
  assign w_s1_adv     = !r_s1_valid || w_s2_adv;
  assign bus.in_ready = w_s1_adv;

  assign w_m = DATA_W'(expand_mask(MAX_LANES'(bus.in_mask), LANE_W, NLANES));

  // One-hot marker of the lowest selected lane; all zero for an empty mask,
  // which makes the broadcast source fall out as 0 without a special case.
  always_comb begin
    w_first = '0;
    w_seen  = 1'b0;
    for (int i = 0; i < NLANES; i++) begin
      w_first[i] = bus.in_mask[i] & ~w_seen;
      w_seen     = w_seen | bus.in_mask[i];
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [DATA_W-1:0] w_ch;
    logic [LANE_W-1:0] w_lane;

    assign w_ch = bus.in_data[gi*DATA_W +: DATA_W];

    always_comb begin
      w_lane = '0;
      for (int i = 0; i < NLANES; i++) begin
        if (w_first[i]) begin
          w_lane = w_lane | w_ch[i*LANE_W +: LANE_W];
        end
      end
    end

    assign w_x[gi*DATA_W +: DATA_W] = w_ch & w_m;
    assign w_l[gi*LANE_W +: LANE_W] = w_lane;

    lane_copier_op #(
      .DATA_W (DATA_W),
      .LANE_W (LANE_W)
    ) u_op (
      .i_x    (r_s1_x[gi*DATA_W +: DATA_W]),
      .i_m    (r_s1_m),
      .i_l    (r_s1_l[gi*LANE_W +: LANE_W]),
      .i_mode (r_s1_mode),
      .o_y    (w_y[gi*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_m     <= '0;
      r_s1_mode  <= MODE_COPY;
      r_s1_l     <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          r_s1_x    <= w_x;
          r_s1_m    <= w_m;
          r_s1_mode <= mode_e'(bus.in_mode);
          r_s1_l    <= w_l;
        end
      end
      // out_data only changes when a real beat moves in, so it stays put
      // while a beat waits for out_ready.
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= w_y;
        end
      end
    end
  end

  assign bus.out_valid = r_s2_valid;
  assign bus.out_data  = r_s2_data;

endmodule
